matrix_ls_sequencer: RTL and testbench

//  Executes decoded ld.m / st.m operations (fields: matrix_rd, base, stride, imm, m_mem_type).

---
 rtl/matrix_ls_sequencer.sv | 171 +++++++++++++++++
 tb/tb_matrix_ls_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ls_sequencer.sv
// Row-by-row ld.m / st.m sequencer between issue, the dcache and the matrix register file.
// Optional MATRIX_LS_ALIGN_CHECK_EN aborts ops whose start address or stride is not row-aligned.
module matrix_ls_sequencer #(
  parameter int WORD_W = 32,
  parameter int ROWS   = 4,
  parameter int ROW_W  = 64,
  parameter int MREG_W = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [1:0]               m_mem_type,
  input  logic [MREG_W-1:0]        matrix_rd,
  input  logic [WORD_W-1:0]        base,
  input  logic [WORD_W-1:0]        stride,
  input  logic [10:0]              imm,
  output logic                     mem_req,
  output logic                     mem_wen,
  output logic [WORD_W-1:0]        mem_addr,
  output logic [ROW_W-1:0]         mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [ROW_W-1:0]         mem_rdata,
  output logic                     mrf_wen,
  output logic [MREG_W-1:0]        mrf_waddr,
  output logic [$clog2(ROWS)-1:0]  mrf_wrow,
  output logic [ROW_W-1:0]         mrf_wdata,
  output logic [MREG_W-1:0]        mrf_raddr,
  output logic [$clog2(ROWS)-1:0]  mrf_rrow,
  input  logic [ROW_W-1:0]         mrf_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);
  localparam logic [1:0] T_LOAD  = 2'b01;
  localparam logic [1:0] T_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [RW-1:0]       row, row_nxt;
  logic [WORD_W-1:0]   addr, addr_nxt;
  logic [WORD_W-1:0]   stride_q, stride_nxt;
  logic [MREG_W-1:0]   rd_q, rd_nxt;
  logic                store_q, store_nxt;
  logic [WORD_W-1:0]   start_addr;
  logic                misalign;

  assign start_addr = base + {{(WORD_W-11){imm[10]}}, imm};

`ifdef MATRIX_LS_ALIGN_CHECK_EN
  localparam int ALIGN_B = ROW_W / 8;
  logic err_q, err_nxt;
  assign misalign = ((start_addr % WORD_W'(ALIGN_B)) != '0) ||
                    ((stride % WORD_W'(ALIGN_B)) != '0);
  assign err      = (state == DONE) && err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      row      <= '0;
      addr     <= '0;
      stride_q <= '0;
      rd_q     <= '0;
      store_q  <= 1'b0;
`ifdef MATRIX_LS_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      addr     <= addr_nxt;
      stride_q <= stride_nxt;
      rd_q     <= rd_nxt;
      store_q  <= store_nxt;
`ifdef MATRIX_LS_ALIGN_CHECK_EN
      err_q    <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    addr_nxt    = addr;
    stride_nxt  = stride_q;
    rd_nxt      = rd_q;
    store_nxt   = store_q;
`ifdef MATRIX_LS_ALIGN_CHECK_EN
    err_nxt     = err_q;
`endif
    issue_ready = 1'b0;
    mem_req     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mrf_wen     = 1'b0;
    mrf_wdata   = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          rd_nxt     = matrix_rd;
          stride_nxt = stride;
          addr_nxt   = start_addr;
          row_nxt    = '0;
          store_nxt  = (m_mem_type == T_STORE);
`ifdef MATRIX_LS_ALIGN_CHECK_EN
          err_nxt    = misalign;
`endif
          // Misaligned and illegal ops retire through DONE without touching memory
          if (misalign)
            state_nxt = DONE;
          else if (m_mem_type == T_LOAD || m_mem_type == T_STORE)
            state_nxt = REQ;
          else
            state_nxt = DONE;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_wen   = store_q;
        mem_addr  = addr;
        mem_wdata = mrf_rdata;
        if (mem_ready) begin
          if (!store_q)
            state_nxt = WAIT;
          else if (row == LAST_ROW)
            state_nxt = DONE;
          else begin
            row_nxt  = row + RW'(1);
            addr_nxt = addr + stride_q;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          mrf_wen   = 1'b1;
          mrf_wdata = mem_rdata;
          if (row == LAST_ROW)
            state_nxt = DONE;
          else begin
            row_nxt   = row + RW'(1);
            addr_nxt  = addr + stride_q;
            state_nxt = REQ;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mrf_waddr = rd_q;
  assign mrf_wrow  = row;
  assign mrf_raddr = rd_q;
  assign mrf_rrow  = row;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Scoreboard bench for matrix_ls_sequencer: expected requests, RF writes and completions
// are queued when an op is issued and popped as the DUT produces them.
module tb_matrix_ls_sequencer;
  localparam int WORD_W = 32, ROWS = 4, ROW_W = 64, MREG_W = 4;

  logic CLK = 1'b0, nRST = 1'b0;
  logic issue_valid = 1'b0, issue_ready;
  logic [1:0] m_mem_type = 2'b00;
  logic [MREG_W-1:0] matrix_rd = '0;
  logic [WORD_W-1:0] base = '0, stride = '0;
  logic [10:0] imm = '0;
  logic mem_req, mem_wen, mem_ready;
  logic [WORD_W-1:0] mem_addr;
  logic [ROW_W-1:0] mem_wdata, mrf_wdata, mrf_rdata;
  logic mem_rvalid = 1'b0;
  logic [ROW_W-1:0] mem_rdata = '0;
  logic mrf_wen, busy, done, err;
  logic [MREG_W-1:0] mrf_waddr, mrf_raddr;
  logic [1:0] mrf_wrow, mrf_rrow;

  logic rdy_man = 1'b1, rnd_ready = 1'b0, rnd_bit = 1'b1;
  assign mem_ready = rnd_ready ? rnd_bit : rdy_man;
  assign mrf_rdata = {16'hBEEF, 4'h0, mrf_raddr, 6'h0, mrf_rrow, 32'h13579BDF};

  matrix_ls_sequencer #(.WORD_W(WORD_W), .ROWS(ROWS), .ROW_W(ROW_W), .MREG_W(MREG_W)) dut (
    .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .m_mem_type(m_mem_type), .matrix_rd(matrix_rd), .base(base), .stride(stride), .imm(imm),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mrf_wen(mrf_wen), .mrf_waddr(mrf_waddr), .mrf_wrow(mrf_wrow), .mrf_wdata(mrf_wdata),
    .mrf_raddr(mrf_raddr), .mrf_rrow(mrf_rrow), .mrf_rdata(mrf_rdata),
    .busy(busy), .done(done), .err(err));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic wen; logic [31:0] addr; logic [63:0] wdata;} req_t;
  typedef struct packed {logic [3:0] rd; logic [1:0] row; logic [63:0] data;} wr_t;
  req_t req_q[$];
  wr_t  wr_q[$];
  logic done_q[$];

  function automatic logic [63:0] rowdat(input logic [31:0] a);
    return {a ^ 32'h5A5A5A5A, ~a};
  endfunction
  function automatic logic [63:0] rfdat(input logic [3:0] rd, input logic [1:0] r);
    return {16'hBEEF, 4'h0, rd, 6'h0, r, 32'h13579BDF};
  endfunction

  // Memory: load data returned the cycle after the accepted read request
  always @(posedge CLK) begin
    logic hs;
    logic [31:0] a;
    hs = mem_req && mem_ready && !mem_wen;
    a  = mem_addr;
    #1;
    mem_rvalid = hs;
    mem_rdata  = hs ? rowdat(a) : 64'h0;
    rnd_bit    = ($urandom_range(0, 3) != 0);
  end

  always @(negedge CLK) begin
    req_t er;
    wr_t  ew;
    logic ee;
    if (nRST) begin
      if (mem_req && mem_ready) begin
        if (req_q.size() == 0) chk("req_extra", 1, 0);
        else begin
          er = req_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(er.addr));
          chk("mem_wen", 64'(mem_wen), 64'(er.wen));
          chk("mem_wdata", mem_wdata, er.wdata);
        end
      end
      if (mrf_wen) begin
        if (wr_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          ew = wr_q.pop_front();
          chk("mrf_waddr", 64'(mrf_waddr), 64'(ew.rd));
          chk("mrf_wrow", 64'(mrf_wrow), 64'(ew.row));
          chk("mrf_wdata", mrf_wdata, ew.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_extra", 1, 0);
        else begin
          ee = done_q.pop_front();
          chk("err", 64'(err), 64'(ee));
        end
      end else if (err) chk("err_nodone", 64'(err), 0);
    end
  end

  task automatic push_op(input logic [1:0] t, input logic [3:0] rd, input logic [31:0] b,
                         input logic [10:0] im, input logic [31:0] st);
    logic [31:0] a;
    logic mis;
    a   = b + {{21{im[10]}}, im};
    mis = 1'b0;
`ifdef MATRIX_LS_ALIGN_CHECK_EN
    mis = (a[2:0] != 3'b0) || (st[2:0] != 3'b0);
`endif
    if (mis) done_q.push_back(1'b1);
    else begin
      if (t == 2'b01 || t == 2'b10)
        for (int r = 0; r < ROWS; r++) begin
          req_q.push_back('{t == 2'b10, a, rfdat(rd, 2'(r))});
          if (t == 2'b01) wr_q.push_back('{rd, 2'(r), rowdat(a)});
          a = a + st;
        end
      done_q.push_back(1'b0);
    end
  endtask

  task automatic start_op(input logic [1:0] t, input logic [3:0] rd, input logic [31:0] b,
                          input logic [10:0] im, input logic [31:0] st);
    push_op(t, rd, b, im, st);
    @(negedge CLK);
    chk("issue_ready", 64'(issue_ready), 1);
    issue_valid = 1'b1; m_mem_type = t; matrix_rd = rd; base = b; imm = im; stride = st;
    @(posedge CLK);
    #1;
    issue_valid = 1'b0; m_mem_type = 2'b00;
    chk("busy", 64'(busy), 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done && n < 300);
    if (!done) chk("done_timeout", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  int lat;
  logic [31:0] a0;
  logic [63:0] w0;

  initial begin
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 1);
    chk("rst_outs", {busy, done, err, mem_req, mrf_wen, mem_wen}, 0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    start_op(2'b10, 4'd3, 32'h1000, 11'h010, 32'h20);
    wait_done(lat); chk("store_lat", 64'(lat), ROWS + 1);

    start_op(2'b01, 4'd5, 32'h2000, 11'h7F8, 32'h8);
    wait_done(lat); chk("load_lat", 64'(lat), 2 * ROWS + 1);

    rdy_man = 1'b0;
    start_op(2'b10, 4'd1, 32'h3000, 11'h000, 32'h40);
    @(negedge CLK);
    a0 = mem_addr; w0 = mem_wdata;
    chk("bp_addr0", 64'(a0), 64'h3000);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_req", 64'(mem_req), 1);
      chk("bp_addr", 64'(mem_addr), 64'(a0));
      chk("bp_wdata", mem_wdata, w0);
      chk("bp_row", 64'(mrf_rrow), 0);
    end
    rdy_man = 1'b1;
    wait_done(lat);

    start_op(2'b01, 4'd2, 32'hFFFFFFF0, 11'h000, 32'h10);
    wait_done(lat); chk("wrap_lat", 64'(lat), 2 * ROWS + 1);
    start_op(2'b10, 4'd7, 32'h4000, 11'h008, 32'h0);
    wait_done(lat);
    start_op(2'b01, 4'd9, 32'h5000, 11'h018, 32'hFFFFFFF0);
    wait_done(lat);
    start_op(2'b11, 4'd4, 32'h6000, 11'h000, 32'h8);
    wait_done(lat); chk("illegal_lat", 64'(lat), 1);
    start_op(2'b00, 4'd4, 32'h6000, 11'h000, 32'h8);
    wait_done(lat); chk("illegal0_lat", 64'(lat), 1);

    // Reset mid-load while row 2 is being requested
    start_op(2'b01, 4'd4, 32'h6000, 11'h000, 32'h8);
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!(mem_req && mrf_rrow == 2'd2) && lat < 50);
    chk("row2_reached", 64'(mrf_rrow), 2);
    nRST = 1'b0;
    #1;
    chk("mrst_issue_ready", 64'(issue_ready), 1);
    chk("mrst_outs", {busy, done, err, mem_req, mrf_wen, mem_wen}, 0);
    chk("mrst_addr", 64'(mem_addr), 0);
    chk("mrst_row", {mrf_rrow, mrf_wrow}, 0);
    req_q.delete(); wr_q.delete(); done_q.delete();
    @(posedge CLK);
    #1 nRST = 1'b1;
    start_op(2'b01, 4'd6, 32'h7000, 11'h000, 32'h8);
    wait_done(lat); chk("post_rst_lat", 64'(lat), 2 * ROWS + 1);

    start_op(2'b01, 4'd1, 32'h1004, 11'h000, 32'h8);
    wait_done(lat);
`ifdef MATRIX_LS_ALIGN_CHECK_EN
    chk("misalign_lat", 64'(lat), 1);
`else
    chk("misalign_lat", 64'(lat), 2 * ROWS + 1);
`endif

    rnd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] t;
      t = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      start_op(t, 4'($urandom_range(0, 15)), $urandom() & 32'hFFFFFFF8,
               {$urandom_range(0, 255), 3'b000} & 11'h7FF,
               ($urandom() & 32'h000001F8) ^ (($urandom_range(0, 1) != 0) ? 32'hFFFFFFF8 : 32'h0));
      wait_done(lat);
    end
    rnd_ready = 1'b0;

    repeat (3) @(negedge CLK);
    chk("req_q_empty", 64'(req_q.size()), 0);
    chk("wr_q_empty", 64'(wr_q.size()), 0);
    chk("done_q_empty", 64'(done_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
